// File: rtl/griffin_batch_loader.sv
`timescale 1ns/1ps
// griffin_batch_loader
// Serial stream -> three Griffin lane states. Each incoming word is reduced
// into [0, PRIME_MODULUS) on the write path. Once a full batch is stored, a
// one-cycle perm_enable is issued. The states are then held until the
// permutation reports done.
module griffin_batch_loader #(
    parameter int                  N_BITS        = 254,
    parameter logic [N_BITS-1:0]   PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                  STATE_SIZE    = 3,
    parameter int                  NUM_LANES     = 3,
    parameter int                  DEPTH         = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_data,
    input  logic              flush,
    input  logic              perm_done,
    output logic              perm_enable,
    output logic [N_BITS-1:0] stateOut1 [STATE_SIZE][DEPTH],
    output logic [N_BITS-1:0] stateOut2 [STATE_SIZE][DEPTH],
    output logic [N_BITS-1:0] stateOut3 [STATE_SIZE][DEPTH],
    output logic              busy,
    output logic              reduced_flag,
    output logic [15:0]       batch_count
);

    localparam int LANE_WORDS = STATE_SIZE * DEPTH;
    localparam int TOTAL      = NUM_LANES * LANE_WORDS;
    localparam int CW         = $clog2(TOTAL);

    localparam logic [CW-1:0] LAST_C       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] LANE_WORDS_C = CW'(LANE_WORDS);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Single conditional subtract; 2^N_BITS < 2*PRIME_MODULUS, so one step suffices.
    function automatic logic [N_BITS-1:0] reduce_word(input logic [N_BITS-1:0] w);
        logic [N_BITS-1:0] r;
        if (w >= PRIME_MODULUS) begin
            r = w - PRIME_MODULUS;
        end else begin
            r = w;
        end
        return r;
    endfunction

    // The word needs reduction when it is at or above the modulus.
    function automatic logic needs_reduce(input logic [N_BITS-1:0] w);
        return (w >= PRIME_MODULUS);
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              red_q, red_d;
    logic [15:0]       bc_q, bc_d;
    logic              in_ready_q, in_ready_d;
    logic              perm_enable_q, perm_enable_d;
    logic              busy_q, busy_d;
    logic              wait_first_q, wait_first_d;
    logic              wr_en_s;

    logic [CW-1:0]     lane_s, rem_s, row_s, col_s;
    logic [N_BITS-1:0] wr_data_s;

    logic [N_BITS-1:0] st_q [NUM_LANES][STATE_SIZE][DEPTH];

    // Decode the word counter into lane / row / column and reduce the incoming word.
    always_comb begin
        lane_s    = cnt_q / LANE_WORDS_C;
        rem_s     = cnt_q % LANE_WORDS_C;
        row_s     = rem_s / DEPTH_C;
        col_s     = rem_s % DEPTH_C;
        wr_data_s = reduce_word(in_data);
    end

    // Next-state logic for the LOAD / FIRE / WAIT sequence and its registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        red_d        = red_q;
        bc_d         = bc_q;
        wr_en_s      = 1'b0;
        wait_first_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (flush) begin
                    // Abort the partial batch; stored words get overwritten later.
                    cnt_d = {CW{1'b0}};
                    red_d = 1'b0;
                end else if (in_valid && in_ready_q) begin
                    wr_en_s = 1'b1;
                    if (needs_reduce(in_data)) begin
                        red_d = 1'b1;
                    end else begin
                        red_d = red_q;
                    end
                    if (cnt_q == LAST_C) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_FIRE: begin
                state_d      = S_WAIT;
                wait_first_d = 1'b1;
            end
            S_WAIT: begin
                // A done level left over from the previous batch is masked
                // during the first WAIT cycle.
                if (perm_done && !wait_first_q) begin
                    bc_d    = bc_q + 16'd1;
                    red_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        in_ready_d    = (state_d == S_LOAD);
        perm_enable_d = (state_d == S_FIRE);
        busy_d        = (state_d != S_LOAD);
    end

    // Control registers: FSM, counter, flags and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_LOAD;
            cnt_q         <= {CW{1'b0}};
            red_q         <= 1'b0;
            bc_q          <= 16'd0;
            in_ready_q    <= 1'b0;
            perm_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            wait_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            red_q         <= red_d;
            bc_q          <= bc_d;
            in_ready_q    <= in_ready_d;
            perm_enable_q <= perm_enable_d;
            busy_q        <= busy_d;
            wait_first_q  <= wait_first_d;
        end
    end

    // Lane state storage: the addressed word is written on each accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int i = 0; i < STATE_SIZE; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        st_q[l][i][j] <= {N_BITS{1'b0}};
                    end
                end
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int i = 0; i < STATE_SIZE; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (wr_en_s && (lane_s == CW'(l)) && (row_s == CW'(i)) && (col_s == CW'(j))) begin
                            st_q[l][i][j] <= wr_data_s;
                        end else begin
                            st_q[l][i][j] <= st_q[l][i][j];
                        end
                    end
                end
            end
        end
    end

    assign stateOut1    = st_q[0];
    assign stateOut2    = st_q[1];
    assign stateOut3    = st_q[2];
    assign in_ready     = in_ready_q;
    assign perm_enable  = perm_enable_q;
    assign busy         = busy_q;
    assign reduced_flag = red_q;
    assign batch_count  = bc_q;

endmodule

// File: tb/tb_griffin_batch_loader.sv
`timescale 1ns/1ps
// Self-checking bench for griffin_batch_loader: directed and randomized
// batches are checked against a word-level reference model of the lane states.
module tb_griffin_batch_loader;

    localparam logic [253:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int TOTAL = 117;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [253:0] in_data;
    logic         flush;
    logic         perm_done;
    logic         perm_enable;
    logic [253:0] so1 [3][13];
    logic [253:0] so2 [3][13];
    logic [253:0] so3 [3][13];
    logic         busy;
    logic         reduced_flag;
    logic [15:0]  batch_count;

    griffin_batch_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .perm_done    (perm_done),
        .perm_enable  (perm_enable),
        .stateOut1    (so1),
        .stateOut2    (so2),
        .stateOut3    (so3),
        .busy         (busy),
        .reduced_flag (reduced_flag),
        .batch_count  (batch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;

    // Reference model: expected lane words, pending word index, flag, batch count.
    logic [253:0] exp_st [3][3][13];
    int           exp_k;
    logic         exp_red;
    int           exp_bc;
    logic [253:0] batch_data [TOTAL];

    // Count cycles with perm_enable high.
    always @(negedge clk) begin
        if (perm_enable === 1'b1) en_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [253:0] rand_word();
        logic [255:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[253:0];
    endfunction

    task automatic model_clear();
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 13; j++)
                    exp_st[l][i][j] = 254'd0;
        exp_k   = 0;
        exp_red = 1'b0;
        exp_bc  = 0;
    endtask

    task automatic model_accept(input logic [253:0] d);
        logic [253:0] v;
        v = (d >= P) ? d - P : d;
        if (d >= P) exp_red = 1'b1;
        exp_st[exp_k / 39][(exp_k % 39) / 13][exp_k % 13] = v;
        exp_k = (exp_k + 1) % TOTAL;
    endtask

    task automatic check_states(input string tag);
        logic [253:0] obs;
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 13; j++) begin
                    case (l)
                        0: obs = so1[i][j];
                        1: obs = so2[i][j];
                        default: obs = so3[i][j];
                    endcase
                    check($sformatf("%s_st_l%0d_r%0d_c%0d", tag, l, i, j), obs, exp_st[l][i][j]);
                end
    endtask

    // Feed n words from batch_data with idle_pct percent idle cycles.
    // Starts and ends just after a rising edge.
    task automatic feed(input int n, input int idle_pct, output int ready_cycles);
        int   idx;
        int   cyc;
        logic v;
        idx = 0;
        cyc = 0;
        ready_cycles = 0;
        while (idx < n && cyc < 4000) begin
            v = ($urandom_range(99) >= idle_pct);
            in_valid = v;
            in_data  = v ? batch_data[idx] : rand_word();
            @(negedge clk);
            check("enable_low_in_load", perm_enable, 1'b0);
            if (in_ready) ready_cycles++;
            if (v && in_ready) begin
                model_accept(batch_data[idx]);
                idx++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = 254'd0;
        if (idx < n) check("feed_timeout", 256'(idx), 256'(n));
    endtask

    // FIRE cycle and first WAIT cycle checks; ends at start of second WAIT cycle.
    task automatic fire_check(input string tag);
        @(negedge clk);
        check({tag, "_enable_hi"}, perm_enable, 1'b1);
        check({tag, "_ready_fire"}, in_ready, 1'b0);
        check({tag, "_busy_fire"}, busy, 1'b1);
        step();
        @(negedge clk);
        check({tag, "_enable_one_cycle"}, perm_enable, 1'b0);
        check({tag, "_busy_wait"}, busy, 1'b1);
        check({tag, "_ready_wait"}, in_ready, 1'b0);
        check({tag, "_reduced"}, reduced_flag, exp_red);
        check_states(tag);
        step();
    endtask

    task automatic done_after(input string tag, input int extra);
        repeat (extra) step();
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        exp_bc++;
        exp_red = 1'b0;
        @(negedge clk);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_ready_done"}, in_ready, 1'b1);
        check({tag, "_batch_count"}, batch_count, 16'(exp_bc));
        check({tag, "_reduced_clr"}, reduced_flag, 1'b0);
        step();
    endtask

    initial begin
        int rc;
        int en_base;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 254'd0;
        flush     = 1'b0;
        perm_done = 1'b0;
        model_clear();

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_enable", perm_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_reduced", reduced_flag, 1'b0);
        check("rst_bc", batch_count, 16'd0);
        check("rst_st", so2[1][7], 254'd0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("rel_ready", in_ready, 1'b1);
        step();

        // T1: words k+1, valid held high
        for (int k = 0; k < TOTAL; k++) batch_data[k] = 254'(k + 1);
        feed(TOTAL, 0, rc);
        check("t1_ready_cycles", 256'(rc), 256'd117);
        check("t1_s1_00", so1[0][0], 254'd1);
        check("t1_s1_212", so1[2][12], 254'd39);
        check("t1_s2_00", so2[0][0], 254'd40);
        check("t1_s3_212", so3[2][12], 254'd117);
        fire_check("t1");
        done_after("t1", 0);

        // T2: reduction boundaries
        for (int k = 0; k < TOTAL; k++) batch_data[k] = rand_word();
        batch_data[0] = P;
        batch_data[1] = P + 254'd5;
        batch_data[2] = P - 254'd1;
        feed(TOTAL, 0, rc);
        check("t2_w0", so1[0][0], 254'd0);
        check("t2_w1", so1[0][1], 254'd5);
        check("t2_w2", so1[0][2], P - 254'd1);
        check("t2_red_set", reduced_flag, 1'b1);
        fire_check("t2");
        check("t2_red_hold", reduced_flag, 1'b1);

        // T3: done held high from prior batch through the next batch
        perm_done = 1'b1;
        step();
        exp_bc++;
        exp_red = 1'b0;
        @(negedge clk);
        check("t3_exit_prev", busy, 1'b0);
        check("t3_bc_prev", batch_count, 16'(exp_bc));
        step();
        for (int k = 0; k < TOTAL; k++) batch_data[k] = rand_word();
        feed(TOTAL, 0, rc);
        check("t3_bc_load", batch_count, 16'(exp_bc));
        @(negedge clk);
        check("t3_enable", perm_enable, 1'b1);
        step();
        @(negedge clk);
        check("t3_wait1_busy", busy, 1'b1);
        check("t3_wait1_bc", batch_count, 16'(exp_bc));
        check_states("t3");
        step();
        @(negedge clk);
        check("t3_wait2_busy", busy, 1'b1);
        step();
        exp_bc++;
        exp_red = 1'b0;
        @(negedge clk);
        check("t3_exit_busy", busy, 1'b0);
        check("t3_exit_bc", batch_count, 16'(exp_bc));
        step();
        perm_done = 1'b0;
        check("t3_bc_once", batch_count, 16'(exp_bc));

        // T4: flush after 50 words, then a fresh batch
        for (int k = 0; k < TOTAL; k++) batch_data[k] = rand_word();
        batch_data[0] = P + 254'd1;
        feed(50, 0, rc);
        @(negedge clk);
        check("t4_red_partial", reduced_flag, exp_red);
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 254'd77;
        @(negedge clk);
        check("t4_ready_flush", in_ready, 1'b1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_k    = 0;
        exp_red  = 1'b0;
        @(negedge clk);
        check("t4_red_cleared", reduced_flag, 1'b0);
        check("t4_ready_after", in_ready, 1'b1);
        step();
        for (int k = 0; k < TOTAL; k++) begin
            batch_data[k] = rand_word();
            batch_data[k][253] = 1'b0;
        end
        feed(TOTAL, 0, rc);
        fire_check("t4");
        done_after("t4", 0);

        // T5: asynchronous reset in WAIT
        for (int k = 0; k < TOTAL; k++) batch_data[k] = rand_word();
        feed(TOTAL, 0, rc);
        fire_check("t5");
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("t5_ready", in_ready, 1'b0);
        check("t5_enable", perm_enable, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_reduced", reduced_flag, 1'b0);
        check("t5_bc", batch_count, 16'd0);
        check("t5_s1", so1[0][0], 254'd0);
        check("t5_s3", so3[2][12], 254'd0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("t5_rel_ready", in_ready, 1'b1);
        check("t5_rel_bc", batch_count, 16'd0);
        step();

        // T6: three randomized batches with idle gaps
        en_base = en_cnt;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < TOTAL; k++) batch_data[k] = rand_word();
            feed(TOTAL, 30, rc);
            fire_check($sformatf("t6b%0d", b));
            done_after($sformatf("t6b%0d", b), 8);
        end
        check("t6_enables", 256'(en_cnt - en_base), 256'd3);
        check("t6_bc", batch_count, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
